// File: rtl/cmac_link_manager.sv
// cmac_link_manager
// Per-channel CMAC link supervisor sharing one rx_clk. Each channel synchronises
// its alignment status, walks RESET -> WAIT_ALIGN -> QUALIFY -> UP, pulses the
// CMAC rx datapath reset when alignment never arrives or is lost, and keeps
// saturating flap / timeout counters for software.

module cmac_link_manager #(
    parameter int          CHANNELS        = 2,
    parameter int unsigned ALIGN_CYCLES    = 644531250,
    parameter int unsigned RESET_CYCLES    = 50,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int          CNT_W           = 16
) (
    input  logic                      rx_clk,
    input  logic                      rx_reset,
    input  logic [CHANNELS-1:0]       stat_rx_aligned,
    input  logic [CHANNELS-1:0]       force_reset,
    input  logic                      clear_counts,
    output logic [CHANNELS-1:0]       reset_rx_datapath,
    output logic [CHANNELS-1:0]       ctl_tx_enable,
    output logic [CHANNELS-1:0]       ctl_tx_send_rfi,
    output logic [CHANNELS-1:0]       link_up,
    output logic [CHANNELS*CNT_W-1:0] flap_count,
    output logic [CHANNELS*CNT_W-1:0] timeout_count
);

    typedef enum logic [1:0] {
        ST_RESET      = 2'd0,
        ST_WAIT_ALIGN = 2'd1,
        ST_QUALIFY    = 2'd2,
        ST_UP         = 2'd3
    } link_state_t;

    localparam logic [31:0]      RESET_LOAD    = 32'(RESET_CYCLES);
    localparam logic [31:0]      ALIGN_LOAD    = 32'(ALIGN_CYCLES);
    localparam logic [31:0]      DEBOUNCE_LOAD = 32'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};

    // Synchroniser stages
    logic [CHANNELS-1:0] sync_meta;
    logic [CHANNELS-1:0] aligned_s;

    // Per-channel FSM state and its two down-counters
    link_state_t state    [CHANNELS];
    link_state_t state_nx [CHANNELS];
    logic [31:0] timer    [CHANNELS];
    logic [31:0] timer_nx [CHANNELS];
    logic [31:0] qual     [CHANNELS];
    logic [31:0] qual_nx  [CHANNELS];

    // Events raised by the FSM for the counters
    logic [CHANNELS-1:0] flap_evt;
    logic [CHANNELS-1:0] timeout_evt;

    // Next values of the registered state decodes
    logic [CHANNELS-1:0] reset_nx;
    logic [CHANNELS-1:0] link_up_nx;

    // Saturating statistics
    logic [CNT_W-1:0] flap_q    [CHANNELS];
    logic [CNT_W-1:0] timeout_q [CHANNELS];

    // Two-flop synchroniser bringing the asynchronous alignment status into rx_clk
    always_ff @(posedge rx_clk or posedge rx_reset) begin
        if (rx_reset) begin
            sync_meta <= '0;
            aligned_s <= '0;
        end else begin
            sync_meta <= stat_rx_aligned;
            aligned_s <= sync_meta;
        end
    end

    assign ctl_tx_enable   = aligned_s;
    assign ctl_tx_send_rfi = ~aligned_s;

    // State register: FSM state, timers and the registered state decodes
    always_ff @(posedge rx_clk or posedge rx_reset) begin
        if (rx_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i] <= ST_RESET;
                timer[i] <= RESET_LOAD;
                qual[i]  <= '0;
            end
            reset_rx_datapath <= '1;
            link_up           <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i] <= state_nx[i];
                timer[i] <= timer_nx[i];
                qual[i]  <= qual_nx[i];
            end
            reset_rx_datapath <= reset_nx;
            link_up           <= link_up_nx;
        end
    end

    // Next-state logic; force_reset overrides everything, alignment beats a timeout
    always_comb begin
        flap_evt    = '0;
        timeout_evt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_nx[i] = state[i];
            timer_nx[i] = timer[i];
            qual_nx[i]  = qual[i];

            if (force_reset[i]) begin
                state_nx[i] = ST_RESET;
                timer_nx[i] = RESET_LOAD;
            end else begin
                case (state[i])
                    ST_RESET: begin
                        if (timer[i] <= 32'd1) begin
                            state_nx[i] = ST_WAIT_ALIGN;
                            timer_nx[i] = ALIGN_LOAD;
                        end else begin
                            timer_nx[i] = timer[i] - 32'd1;
                        end
                    end

                    ST_WAIT_ALIGN: begin
                        if (aligned_s[i]) begin
                            state_nx[i] = ST_QUALIFY;
                            qual_nx[i]  = DEBOUNCE_LOAD;
                        end else if (timer[i] <= 32'd1) begin
                            state_nx[i]    = ST_RESET;
                            timer_nx[i]    = RESET_LOAD;
                            timeout_evt[i] = 1'b1;
                        end else begin
                            timer_nx[i] = timer[i] - 32'd1;
                        end
                    end

                    ST_QUALIFY: begin
                        if (!aligned_s[i]) begin
                            state_nx[i] = ST_WAIT_ALIGN;
                            timer_nx[i] = ALIGN_LOAD;
                        end else if (qual[i] <= 32'd1) begin
                            state_nx[i] = ST_UP;
                            qual_nx[i]  = '0;
                        end else begin
                            qual_nx[i] = qual[i] - 32'd1;
                        end
                    end

                    ST_UP: begin
                        if (!aligned_s[i]) begin
                            state_nx[i] = ST_RESET;
                            timer_nx[i] = RESET_LOAD;
                            flap_evt[i] = 1'b1;
                        end
                    end

                    default: begin
                        state_nx[i] = ST_RESET;
                        timer_nx[i] = RESET_LOAD;
                    end
                endcase
            end
        end
    end

    // Output decode of the upcoming state, registered in the state register
    always_comb begin
        reset_nx   = '0;
        link_up_nx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            reset_nx[i]   = (state_nx[i] == ST_RESET);
            link_up_nx[i] = (state_nx[i] == ST_UP);
        end
    end

    // Saturating counters; a clear wins over an increment in the same cycle
    always_ff @(posedge rx_clk or posedge rx_reset) begin
        if (rx_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                flap_q[i]    <= '0;
                timeout_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (clear_counts) begin
                    flap_q[i] <= '0;
                end else if (flap_evt[i] && (flap_q[i] != CNT_MAX)) begin
                    flap_q[i] <= flap_q[i] + 1'b1;
                end

                if (clear_counts) begin
                    timeout_q[i] <= '0;
                end else if (timeout_evt[i] && (timeout_q[i] != CNT_MAX)) begin
                    timeout_q[i] <= timeout_q[i] + 1'b1;
                end
            end
        end
    end

    // Pack the per-channel counters onto the flat output buses
    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
        assign flap_count[g*CNT_W +: CNT_W]    = flap_q[g];
        assign timeout_count[g*CNT_W +: CNT_W] = timeout_q[g];
    end

endmodule

// File: tb/tb_cmac_link_manager.sv
// tb_cmac_link_manager
// Bench for cmac_link_manager. A behavioural model predicts every output after
// each rx_clk edge and queues it; a monitor pops and compares on the falling edge.

module tb_cmac_link_manager;

    localparam int CH    = 2;
    localparam int ALIGN = 100;
    localparam int RST   = 5;
    localparam int DEB   = 8;
    // Narrow counters so saturation is reachable in a short run
    localparam int CW    = 4;
    localparam int OW    = 4*CH + 2*CH*CW;
    localparam int CMAX  = (1 << CW) - 1;

    localparam int M_RESET = 0;
    localparam int M_WAIT  = 1;
    localparam int M_QUAL  = 2;
    localparam int M_UP    = 3;

    localparam logic [OW-1:0] RESET_VEC = {{CH{1'b1}}, {CH{1'b0}}, {CH{1'b1}}, {CH{1'b0}}, {(2*CH*CW){1'b0}}};

    logic             rx_clk = 1'b0;
    logic             rx_reset;
    logic [CH-1:0]    stat_rx_aligned;
    logic [CH-1:0]    force_reset;
    logic             clear_counts;
    logic [CH-1:0]    reset_rx_datapath;
    logic [CH-1:0]    ctl_tx_enable;
    logic [CH-1:0]    ctl_tx_send_rfi;
    logic [CH-1:0]    link_up;
    logic [CH*CW-1:0] flap_count;
    logic [CH*CW-1:0] timeout_count;
    logic [OW-1:0]    dut_vec;

    int checks = 0;
    int errors = 0;

    // Reference model: mode plus cycles spent in it, counters, synchroniser history
    int m_mode [CH];
    int m_age  [CH];
    int m_flap [CH];
    int m_to   [CH];
    bit m_s1   [CH];
    bit m_s2   [CH];

    logic [OW-1:0] exp_q [$];
    logic [OW-1:0] exp_now;
    logic [CH-1:0] rnd_stat;
    logic [CH-1:0] rnd_force;

    cmac_link_manager #(
        .CHANNELS        (CH),
        .ALIGN_CYCLES    (ALIGN),
        .RESET_CYCLES    (RST),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW)
    ) dut (
        .rx_clk            (rx_clk),
        .rx_reset          (rx_reset),
        .stat_rx_aligned   (stat_rx_aligned),
        .force_reset       (force_reset),
        .clear_counts      (clear_counts),
        .reset_rx_datapath (reset_rx_datapath),
        .ctl_tx_enable     (ctl_tx_enable),
        .ctl_tx_send_rfi   (ctl_tx_send_rfi),
        .link_up           (link_up),
        .flap_count        (flap_count),
        .timeout_count     (timeout_count)
    );

    assign dut_vec = {reset_rx_datapath, ctl_tx_enable, ctl_tx_send_rfi, link_up, flap_count, timeout_count};

    always #5 rx_clk = ~rx_clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] model_outputs();
        logic [CH-1:0]    r;
        logic [CH-1:0]    e;
        logic [CH-1:0]    u;
        logic [CH*CW-1:0] f;
        logic [CH*CW-1:0] t;
        for (int i = 0; i < CH; i++) begin
            r[i] = (m_mode[i] == M_RESET);
            e[i] = m_s2[i];
            u[i] = (m_mode[i] == M_UP);
            f[i*CW +: CW] = CW'(m_flap[i]);
            t[i*CW +: CW] = CW'(m_to[i]);
        end
        return {r, e, ~e, u, f, t};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_mode[i] = M_RESET;
            m_age[i]  = 0;
            m_flap[i] = 0;
            m_to[i]   = 0;
            m_s1[i]   = 1'b0;
            m_s2[i]   = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < CH; i++) begin
            bit al;
            bit got_flap;
            bit got_to;
            al       = m_s2[i];
            got_flap = 1'b0;
            got_to   = 1'b0;
            if (force_reset[i]) begin
                m_mode[i] = M_RESET;
                m_age[i]  = 0;
            end else if (m_mode[i] == M_RESET) begin
                m_age[i]++;
                if (m_age[i] == RST) begin
                    m_mode[i] = M_WAIT;
                    m_age[i]  = 0;
                end
            end else if (m_mode[i] == M_WAIT) begin
                if (al) begin
                    m_mode[i] = M_QUAL;
                    m_age[i]  = 0;
                end else begin
                    m_age[i]++;
                    if (m_age[i] == ALIGN) begin
                        got_to    = 1'b1;
                        m_mode[i] = M_RESET;
                        m_age[i]  = 0;
                    end
                end
            end else if (m_mode[i] == M_QUAL) begin
                if (al) begin
                    m_age[i]++;
                    if (m_age[i] == DEB) begin
                        m_mode[i] = M_UP;
                        m_age[i]  = 0;
                    end
                end else begin
                    m_mode[i] = M_WAIT;
                    m_age[i]  = 0;
                end
            end else begin
                if (!al) begin
                    got_flap  = 1'b1;
                    m_mode[i] = M_RESET;
                    m_age[i]  = 0;
                end
            end

            if (clear_counts) begin
                m_flap[i] = 0;
                m_to[i]   = 0;
            end else begin
                if (got_flap && m_flap[i] < CMAX) m_flap[i]++;
                if (got_to && m_to[i] < CMAX) m_to[i]++;
            end

            m_s2[i] = m_s1[i];
            m_s1[i] = stat_rx_aligned[i];
        end
    endtask

    // Model advances on every edge and queues its prediction of the outputs
    always @(posedge rx_clk or posedge rx_reset) begin
        if (rx_reset) begin
            model_reset();
            exp_q.delete();
            exp_q.push_back(model_outputs());
        end else begin
            model_step();
            exp_q.push_back(model_outputs());
        end
    end

    // Monitor compares the DUT against each queued prediction away from the edge
    always @(negedge rx_clk) begin
        if (exp_q.size() != 0) begin
            exp_now = exp_q.pop_front();
            checkOutput("cycle", 64'(dut_vec), 64'(exp_now));
        end
    end

    // Drive inputs for n cycles; force and clear last only for the first one
    task automatic applyStimulus(input logic [CH-1:0] s, input logic [CH-1:0] f, input logic c, input int n);
        stat_rx_aligned = s;
        force_reset     = f;
        clear_counts    = c;
        for (int k = 0; k < n; k++) begin
            @(posedge rx_clk);
            #1;
            force_reset  = '0;
            clear_counts = 1'b0;
        end
    endtask

    task automatic wait_for_mode(input int ch, input int mode, input int age, input string name);
        int k;
        k = 0;
        while (!(m_mode[ch] == mode && (age < 0 || m_age[ch] == age)) && k < 3000) begin
            @(posedge rx_clk);
            #1;
            k++;
        end
        if (k >= 3000) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: wait bound expired, mode %0d required %0d", name, m_mode[ch], mode);
        end
    endtask

    initial begin
        rx_reset        = 1'b1;
        stat_rx_aligned = '0;
        force_reset     = '0;
        clear_counts    = 1'b0;
        repeat (3) @(posedge rx_clk);
        @(negedge rx_clk);
        checkOutput("reset_state", 64'(dut_vec), 64'(RESET_VEC));
        @(posedge rx_clk);
        #1;
        rx_reset = 1'b0;

        $display("[TB] T1 aligned held low");
        applyStimulus('0, '0, 1'b0, 230);
        @(negedge rx_clk);
        checkOutput("t1_timeouts", 64'(timeout_count), 64'({4'd2, 4'd2}));

        $display("[TB] T5 timeout saturation and coincident clear");
        applyStimulus('0, '0, 1'b0, 16*(RST+ALIGN));
        @(negedge rx_clk);
        checkOutput("t5_saturated", 64'(timeout_count), 64'({4'hF, 4'hF}));
        wait_for_mode(0, M_WAIT, ALIGN-1, "t5_wait");
        applyStimulus('0, '0, 1'b1, 1);
        @(negedge rx_clk);
        checkOutput("t5_clear_wins", 64'(timeout_count), 64'(0));

        $display("[TB] T2 qualify to link up");
        wait_for_mode(0, M_WAIT, 20, "t2_wait");
        applyStimulus(2'b01, '0, 1'b0, 10);
        @(negedge rx_clk);
        checkOutput("t2_link_before", 64'(link_up[0]), 64'(0));
        @(posedge rx_clk);
        #1;
        @(negedge rx_clk);
        checkOutput("t2_link_after", 64'(link_up[0]), 64'(1));
        @(posedge rx_clk);
        #1;

        $display("[TB] T3 one-cycle alignment loss in UP");
        applyStimulus(2'b11, '0, 1'b0, 5);
        applyStimulus(2'b10, '0, 1'b0, 1);
        applyStimulus(2'b11, '0, 1'b0, 40);
        @(negedge rx_clk);
        checkOutput("t3_flap", 64'(flap_count), 64'({4'd0, 4'd1}));
        @(posedge rx_clk);
        #1;

        $display("[TB] T4 glitch during qualify");
        applyStimulus(2'b11, 2'b01, 1'b0, 1);
        wait_for_mode(0, M_QUAL, 1, "t4_qual");
        applyStimulus(2'b10, '0, 1'b0, 1);
        applyStimulus(2'b11, '0, 1'b0, 30);
        @(negedge rx_clk);
        checkOutput("t4_counts", 64'({flap_count, timeout_count}), 64'({4'd0, 4'd1, 8'h00}));
        @(posedge rx_clk);
        #1;

        $display("[TB] T6 force_reset in UP and async reset");
        wait_for_mode(1, M_UP, -1, "t6_up");
        applyStimulus(2'b11, 2'b10, 1'b0, 1);
        @(negedge rx_clk);
        checkOutput("t6_force", 64'({reset_rx_datapath[1], link_up[1], flap_count[CW +: CW]}), 64'({1'b1, 1'b0, 4'd0}));
        @(posedge rx_clk);
        #1;
        applyStimulus(2'b11, 2'b01, 1'b0, 1);
        wait_for_mode(0, M_QUAL, 2, "t6_qual");
        rx_reset = 1'b1;
        #1;
        checkOutput("t6_async_reset", 64'(dut_vec), 64'(RESET_VEC));
        @(posedge rx_clk);
        @(posedge rx_clk);
        #1;
        rx_reset = 1'b0;

        $display("[TB] randomized traffic");
        rnd_stat = '0;
        for (int n = 0; n < 3000; n++) begin
            rnd_force = '0;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 39) == 0) rnd_stat[c] = ~rnd_stat[c];
                if ($urandom_range(0, 299) == 0) rnd_force[c] = 1'b1;
            end
            applyStimulus(rnd_stat, rnd_force, ($urandom_range(0, 499) == 0), 1);
        end

        applyStimulus('0, '0, 1'b0, 3);
        @(negedge rx_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
